ar_access_controller: RTL and testbench

Sequencer and two-way arbiter for the shared 32-bit address register and memory port. Accepts address requests from the instruction-fetch unit and the data-access unit, grants one at a time round-robin, and drives the address register's `load` / `load_ar_i` strobes and data input. It then runs one memory access and returns a one-cycle acknowledge to the winning requester. It sits between the control unit's requesters and the address register / memory interface.

---
 rtl/ar_access_controller_if.sv | 31 +++
 rtl/ar_access_controller.sv | 110 +++++++++++
 tb/tb_ar_access_controller.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/ar_access_controller_if.sv
// Request/grant and memory-port bundle shared by the address-register access
// controller and its requesters.
interface ar_access_controller_if #(
  parameter int word_size = 32
);
  logic                 f_req;
  logic [word_size-1:0] f_addr;
  logic                 f_ack;
  logic                 d_req;
  logic [word_size-1:0] d_addr;
  logic                 d_we;
  logic                 d_ack;
  logic [word_size-1:0] ar_data;
  logic                 ar_load;
  logic                 ar_load_i;
  logic                 mem_en;
  logic                 mem_we;
  logic                 mem_ready;
  logic                 busy;
  logic                 err;

  modport master (
    output f_req, f_addr, d_req, d_addr, d_we, mem_ready,
    input  f_ack, d_ack, ar_data, ar_load, ar_load_i, mem_en, mem_we, busy, err
  );

  modport slave (
    input  f_req, f_addr, d_req, d_addr, d_we, mem_ready,
    output f_ack, d_ack, ar_data, ar_load, ar_load_i, mem_en, mem_we, busy, err
  );
endinterface

// File: rtl/ar_access_controller.sv
// Round-robin fetch/data arbiter that loads the address register and runs one memory access.
// Optional ACCESS timeout with err pulse is enabled by defining AR_TIMEOUT_EN.
module ar_access_controller #(
  parameter int word_size      = 32,
  parameter int timeout_cycles = 16
) (
  input logic                   clock,
  input logic                   reset,
  ar_access_controller_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, ACCESS, DONE} state_t;

  // Fetch addresses are 20 bits wide; upper bits are forced to zero.
  localparam logic [word_size-1:0] fetch_mask = word_size'(20'hFFFFF);

  state_t state;
  logic   pri;      // 0 = fetch has priority, 1 = data has priority
  logic   win;      // 0 = fetch granted, 1 = data granted
  logic   we_q;
  logic   grant_d;

`ifdef AR_TIMEOUT_EN
  localparam logic [7:0] tlimit = 8'(timeout_cycles - 1);
  logic [7:0] tcnt;
`endif

  always_comb begin
    grant_d = 1'b0;
    if (bus.d_req && (!bus.f_req || pri))
      grant_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      pri           <= 1'b0;
      win           <= 1'b0;
      we_q          <= 1'b0;
      bus.ar_data   <= '0;
      bus.ar_load   <= 1'b0;
      bus.ar_load_i <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.f_ack     <= 1'b0;
      bus.d_ack     <= 1'b0;
      bus.busy      <= 1'b0;
      bus.err       <= 1'b0;
`ifdef AR_TIMEOUT_EN
      tcnt          <= '0;
`endif
    end else begin
      bus.ar_load   <= 1'b0;
      bus.ar_load_i <= 1'b0;
      bus.f_ack     <= 1'b0;
      bus.d_ack     <= 1'b0;
      bus.err       <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.f_req || bus.d_req) begin
            win           <= grant_d;
            we_q          <= bus.d_we;
            bus.ar_data   <= grant_d ? bus.d_addr : (bus.f_addr & fetch_mask);
            bus.ar_load   <= grant_d;
            bus.ar_load_i <= !grant_d;
            bus.busy      <= 1'b1;
            state         <= LOAD;
          end
        end
        LOAD: begin
          bus.mem_en <= 1'b1;
          bus.mem_we <= win & we_q;
`ifdef AR_TIMEOUT_EN
          tcnt       <= '0;
`endif
          state      <= ACCESS;
        end
        ACCESS: begin
          if (bus.mem_ready) begin
            bus.mem_en <= 1'b0;
            bus.mem_we <= 1'b0;
            bus.f_ack  <= !win;
            bus.d_ack  <= win;
            state      <= DONE;
          end
`ifdef AR_TIMEOUT_EN
          // A ready arriving on the limit cycle wins over the timeout.
          else if (tcnt == tlimit) begin
            bus.mem_en <= 1'b0;
            bus.mem_we <= 1'b0;
            bus.f_ack  <= !win;
            bus.d_ack  <= win;
            bus.err    <= 1'b1;
            state      <= DONE;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
`endif
        end
        DONE: begin
          pri      <= ~pri;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ar_access_controller.sv
// Scoreboard bench for ar_access_controller: stimulus queues expected accesses,
// a negedge monitor checks each acknowledge against them.
`timescale 1ns/1ps
module tb_ar_access_controller;
  localparam int word_size      = 32;
  localparam int timeout_cycles = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  ar_access_controller_if #(.word_size(word_size)) bus ();

  ar_access_controller #(
    .word_size(word_size),
    .timeout_cycles(timeout_cycles)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    bit          side;    // 0 fetch, 1 data
    logic [31:0] addr;    // expected ar_data at the load strobe
    bit          we;
    int          cycles;  // expected mem_en cycles
    bit          err;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int applied = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    applied++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic push_exp(input bit side, input logic [31:0] addr, input bit we,
                          input int cycles, input bit err);
    exp_t x;
    x.side = side; x.addr = addr; x.we = we; x.cycles = cycles; x.err = err;
    exp_q.push_back(x);
  endtask

  // Memory model: ready after ready_delay cycles of mem_en (0 = never), or always when held.
  int ready_delay = 1;
  bit ready_hold  = 1'b0;
  int en_cnt      = 0;
  always @(negedge clock) begin
    if (bus.mem_en) en_cnt++;
    else en_cnt = 0;
    bus.mem_ready = ready_hold || (bus.mem_en && ready_delay != 0 && en_cnt >= ready_delay);
  end

  // Monitor: accumulate strobe/access activity, compare on each ack.
  int n_load = 0, n_load_i = 0, n_en = 0, n_we = 0;
  logic [31:0] load_data = '0;
  always @(negedge clock) begin
    if (!reset) begin
      n_load = 0; n_load_i = 0; n_en = 0; n_we = 0;
    end else begin
      if (bus.ar_load)   n_load++;
      if (bus.ar_load_i) n_load_i++;
      if (bus.ar_load || bus.ar_load_i) load_data = bus.ar_data;
      if (bus.mem_en) begin
        n_en++;
        if (bus.mem_we) n_we++;
      end
      if (bus.f_ack && bus.d_ack) begin
        check("ack_overlap", 32'd1, 32'd0);
      end else if (bus.f_ack || bus.d_ack) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", {bus.f_ack, bus.d_ack}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("granted_side", bus.d_ack, e.side);
          check("ar_data", load_data, e.addr);
          check("ar_load_i_pulses", n_load_i, e.side ? 0 : 1);
          check("ar_load_pulses", n_load, e.side ? 1 : 0);
          check("access_cycles", n_en, e.cycles);
          check("mem_we_cycles", n_we, e.we ? e.cycles : 0);
          check("err_at_ack", bus.err, e.err);
        end
        n_load = 0; n_load_i = 0; n_en = 0; n_we = 0;
      end else if (bus.err) begin
        check("stray_err", 32'd1, 32'd0);
      end
    end
  end

  // Requester: raise req, hold it until n acks are seen, then drop it.
  task automatic run(input bit side, input logic [31:0] addr, input bit we, input int n);
    int got = 0;
    @(negedge clock);
    if (side) begin bus.d_req = 1'b1; bus.d_addr = addr; bus.d_we = we; end
    else begin bus.f_req = 1'b1; bus.f_addr = addr; end
    for (int c = 0; c < 200 && got < n; c++) begin
      @(negedge clock);
      if (side ? bus.d_ack : bus.f_ack) got++;
    end
    if (side) bus.d_req = 1'b0;
    else bus.f_req = 1'b0;
    if (got < n) check(side ? "d_ack_timeout" : "f_ack_timeout", got, n);
  endtask

  task automatic wait_mem_en(input string name);
    for (int c = 0; c < 20 && !bus.mem_en; c++) @(negedge clock);
    check(name, bus.mem_en, 1'b1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ar_data"},   bus.ar_data,   32'd0);
    check({tag, "_ar_load"},   bus.ar_load,   32'd0);
    check({tag, "_ar_load_i"}, bus.ar_load_i, 32'd0);
    check({tag, "_mem_en"},    bus.mem_en,    32'd0);
    check({tag, "_mem_we"},    bus.mem_we,    32'd0);
    check({tag, "_f_ack"},     bus.f_ack,     32'd0);
    check({tag, "_d_ack"},     bus.d_ack,     32'd0);
    check({tag, "_busy"},      bus.busy,      32'd0);
    check({tag, "_err"},       bus.err,       32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bus.f_req = 1'b0; bus.d_req = 1'b0;
    bus.f_addr = '0; bus.d_addr = '0; bus.d_we = 1'b0;
    #1;
    check_idle_outputs("reset");
    repeat (3) @(negedge clock);
    reset = 1'b1;

    // Fetch with mem_ready held high: minimum latency.
    ready_hold = 1'b1;
    push_exp(0, 32'h000ABCDE, 0, 1, 0);
    run(0, 32'h000ABCDE, 0, 1);
    ready_hold = 1'b0;

    // Data write, ready on the 4th ACCESS cycle.
    ready_delay = 4;
    push_exp(1, 32'h12345678, 1, 4, 0);
    run(1, 32'h12345678, 1, 1);

    // Fetch address upper bits are dropped.
    ready_delay = 2;
    push_exp(0, 32'h00012345, 0, 2, 0);
    run(0, 32'hFFF12345, 0, 1);

    // Fairness from reset: both held, grants F, D, F, D.
    @(negedge clock); reset = 1'b0;
    repeat (2) @(negedge clock); reset = 1'b1;
    ready_delay = 1;
    push_exp(0, 32'h00011111, 0, 1, 0);
    push_exp(1, 32'h2222AAAA, 1, 1, 0);
    push_exp(0, 32'h00011111, 0, 1, 0);
    push_exp(1, 32'h2222AAAA, 1, 1, 0);
    fork
      run(0, 32'h00011111, 0, 2);
      run(1, 32'h2222AAAA, 1, 2);
    join

    // Move priority to data, then abort a data access with reset.
    push_exp(0, 32'h00000042, 0, 1, 0);
    run(0, 32'h00000042, 0, 1);
    ready_delay = 0;
    @(negedge clock);
    bus.d_req = 1'b1; bus.d_addr = 32'hDEADBEEF; bus.d_we = 1'b1;
    wait_mem_en("abort_reached_access");
    @(negedge clock);
    #2 reset = 1'b0;
    #1 check_idle_outputs("abort");
    bus.d_req = 1'b0;
    repeat (3) @(negedge clock);
    check("abort_busy_held", bus.busy, 32'd0);
    reset = 1'b1;
    ready_delay = 1;
    push_exp(0, 32'h00033333, 0, 1, 0);
    push_exp(1, 32'h44444444, 0, 1, 0);
    fork
      run(0, 32'h00033333, 0, 1);
      run(1, 32'h44444444, 0, 1);
    join

    // One-cycle data request pulse during a fetch access is never granted.
    ready_delay = 5;
    push_exp(0, 32'h00055555, 0, 5, 0);
    fork
      run(0, 32'h00055555, 0, 1);
      begin
        wait_mem_en("pulse_reached_access");
        bus.d_req = 1'b1; bus.d_addr = 32'h66666666; bus.d_we = 1'b0;
        @(negedge clock);
        bus.d_req = 1'b0;
      end
    join
    repeat (4) @(negedge clock);
    check("pulse_back_to_idle", bus.busy, 32'd0);

`ifdef AR_TIMEOUT_EN
    // No ready: timeout after 16 ACCESS cycles with err.
    ready_delay = 0;
    push_exp(1, 32'h0000BEEF, 0, 16, 1);
    run(1, 32'h0000BEEF, 0, 1);
    // Ready on the limit cycle: normal completion.
    ready_delay = 16;
    push_exp(1, 32'h0000CAFE, 0, 16, 0);
    run(1, 32'h0000CAFE, 0, 1);
`endif

    repeat (3) @(negedge clock);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
